db_arbiter: RTL
===============

# db_arbiter

Round-robin request arbiter that shares the single key-lookup port of `db_top` between `NPORT` Ethernet front-ends. Each `eth_top` instance presents lookup requests (key + flag) with a valid/ready handshake. The arbiter grants one request per cycle into `db_top`, records the winner's port ID in an in-order tag FIFO, and steers each `db_top` result (`out_valid`/`out_flag`) back to the requester that issued it. It sits in the `db_clk` domain between the `eth_top` instances and `db_top`.

## Interface
- `NPORT`, 2: number of requesters, 2..8.
- `KEY_SIZE`, 96: lookup key width in bits.
- `TAG_DEPTH`, 8: maximum outstanding lookups inside `db_top`; power of two, 2..32.

- `clk`  in  1  `db_clk`; all logic is clocked on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_key`  in  NPORT*KEY_SIZE  per-port key; port p occupies bits [p*KEY_SIZE +: KEY_SIZE].
- `req_flag`  in  NPORT*4  per-port flag; port p occupies [p*4 +: 4].
- `req_valid`  in  NPORT  request present.
- `req_ready`  out  NPORT  one-hot grant; combinational.
- `resp_valid`  out  NPORT  one-hot result strobe.
- `resp_flag`  out  4  result flag; meaningful only while `resp_valid` is nonzero.
- `db_in_key`  out  KEY_SIZE  to `db_top` `in_key`.
- `db_in_flag`  out  4  to `db_top` `in_flag`.
- `db_in_valid`  out  1  to `db_top` `in_valid`.
- `db_out_valid`  in  1  from `db_top` `out_valid`.
- `db_out_flag`  in  4  from `db_top` `out_flag`.
- `err_orphan`  out  1  sticky; set when a result arrives while the tag FIFO is empty.

## Operation
- **Eligibility.** A port is eligible when `req_valid[p]=1` and the tag count is below `TAG_DEPTH`. A pop in the same cycle does not create room.
- **Arbitration.** Round-robin over eligible ports, searching from `rr_ptr`.
  - The winner w gets `req_ready[w]=1`; all other `req_ready` bits are 0.
  - On a handshake, `rr_ptr` becomes (w+1) mod NPORT.
  - When nothing is granted, `rr_ptr` holds.
- **Issue.** A handshake registers `req_key`/`req_flag` of port w into `db_in_key`/`db_in_flag`, sets `db_in_valid=1` for exactly one cycle, and pushes w into the tag FIFO.
- **Return.** `db_top` returns results in issue order. On `db_out_valid=1`, the FIFO head p is popped and `resp_valid[p]` and `resp_flag` are registered.
- **Simultaneous push and pop.** Both take effect; the count is unchanged.
- **Orphan result.** `db_out_valid=1` with an empty FIFO sets `err_orphan`. The result is dropped, no `resp_valid` is asserted, and the count stays 0. `err_orphan` clears only on reset.
- **Pointer arithmetic.** FIFO pointers are log2(TAG_DEPTH) bits and wrap naturally. The count is log2(TAG_DEPTH)+1 bits.
- **Reset.** Asserting `rst_n` mid-operation discards all outstanding tags. Results still returning from `db_top` after reset count as orphans.

## Timing
- Reset values: `db_in_valid=0`, `db_in_key=0`, `db_in_flag=0`, `resp_valid=0`, `resp_flag=0`, `err_orphan=0`, `rr_ptr=0`, count=0.
- `req_ready` is combinational from `req_valid`, `rr_ptr` and count; it must not depend on `db_out_valid`.
- Issue latency: handshake in cycle t gives `db_in_valid` in cycle t+1.
- Response latency: `db_out_valid` in cycle t gives `resp_valid` in cycle t+1.
- Throughput: one grant per cycle sustained, provided results keep draining.

## Configuration
- **`DB_ARB_STATS_EN` defined:**
  - Adds output `grant_cnt` (NPORT*32 bits), one 32-bit counter per port, incremented on each handshake.
  - Adds output `orphan_cnt` (16 bits), incremented on each orphan result.
  - All counters reset to 0, wrap at their maximum, and update one cycle after the event.
- **Not defined:** these ports and registers do not exist; all other behaviour is identical.

## Test plan
- Single request: NPORT=2, port 1 presents key 0x..AB and flag 0x3 for one cycle, `db_top` model returns flag 0x5 four cycles later -> `db_in_valid` pulses in cycle t+1 with that key; `resp_valid=2'b10`, `resp_flag=0x5` one cycle after `db_out_valid`.
- Fairness: both ports hold `req_valid` for 10 cycles -> grants alternate 0,1,0,1…; each port receives 5 grants.
- Backpressure: TAG_DEPTH=8, model withholds results -> exactly 8 handshakes, then `req_ready=0`. One result releases exactly one new grant, in the cycle after the pop.
- Ordering: 6 lookups interleaved from ports 0/1/0/0/1/1, results with flags 1..6 -> `resp_valid` targets ports 0,1,0,0,1,1 carrying flags 1..6.
- Orphan and reset: `db_out_valid` with an empty FIFO -> `err_orphan=1` and no `resp_valid`. Then assert `rst_n` low with 3 lookups outstanding -> count=0 and `err_orphan=0` after release.

Source files
------------

// File: rtl/db_arbiter.sv
// db_arbiter
// ----------
// Round-robin arbiter sharing the single key-lookup port of db_top between NPORT
// Ethernet front-ends. One request is granted per cycle and registered towards
// db_top. The winner's port ID is pushed into an in-order tag FIFO. Each db_top
// result pops the FIFO head and is steered back to the port that issued it.
// Everything runs in the db_clk domain.
//
// Parameters
//   NPORT      number of requesters (2..8)
//   KEY_SIZE   lookup key width in bits
//   TAG_DEPTH  maximum outstanding lookups (power of two, 2..32)
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   req_key         per-port key, port p at [p*KEY_SIZE +: KEY_SIZE]
//   req_flag        per-port flag, port p at [p*4 +: 4]
//   req_valid       per-port request present
//   req_ready       one-hot grant (combinational)
//   resp_valid      one-hot result strobe (registered)
//   resp_flag       result flag, meaningful while resp_valid != 0
//   db_in_key/flag  registered key/flag towards db_top
//   db_in_valid     one-cycle issue strobe towards db_top
//   db_out_valid    result strobe from db_top
//   db_out_flag     result flag from db_top
//   err_orphan      sticky: a result arrived while no lookup was outstanding
//
// Optional feature (macro DB_ARB_STATS_EN)
//   grant_cnt       NPORT x 32-bit handshake counters, port p at [p*32 +: 32]
//   orphan_cnt      16-bit orphan-result counter
//   Counters reset to 0, wrap at their maximum, and update one cycle after the event.

module db_arbiter #(
  parameter int unsigned NPORT     = 2,
  parameter int unsigned KEY_SIZE  = 96,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NPORT*KEY_SIZE-1:0] req_key,
  input  logic [NPORT*4-1:0]        req_flag,
  input  logic [NPORT-1:0]          req_valid,
  output logic [NPORT-1:0]          req_ready,
  output logic [NPORT-1:0]          resp_valid,
  output logic [3:0]                resp_flag,
  output logic [KEY_SIZE-1:0]       db_in_key,
  output logic [3:0]                db_in_flag,
  output logic                      db_in_valid,
  input  logic                      db_out_valid,
  input  logic [3:0]                db_out_flag,
`ifdef DB_ARB_STATS_EN
  output logic [NPORT*32-1:0]       grant_cnt,
  output logic [15:0]               orphan_cnt,
`endif
  output logic                      err_orphan
);

  localparam int unsigned PtrW  = $clog2(TAG_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned PortW = $clog2(NPORT);

  // Arbitration state
  logic [PortW-1:0] rr_ptr;
  logic [PortW-1:0] win;
  logic             found;
  logic [PortW-1:0] rr_next;
  logic             has_room;
  logic [NPORT-1:0] eligible;

  // Tag FIFO
  logic [PortW-1:0] tag_mem [TAG_DEPTH];
  logic [PtrW-1:0]  wr_ptr;
  logic [PtrW-1:0]  rd_ptr;
  logic [CntW-1:0]  count;
  logic [PortW-1:0] head;
  logic [NPORT-1:0] head_onehot;

  logic push;
  logic pop;
  logic orphan;

  // Room is judged on the registered count only, so a pop in this cycle never
  // opens a slot early and req_ready stays independent of db_out_valid.
  assign has_room = (count < CntW'(TAG_DEPTH));
  assign eligible = req_valid & {NPORT{has_room}};

  // Round-robin search starting at rr_ptr; first eligible port wins.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= int'(NPORT)) begin
        idx = idx - int'(NPORT);
      end
      if (!found && eligible[PortW'(idx)]) begin
        found = 1'b1;
        win   = PortW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found) begin
      req_ready[win] = 1'b1;
    end
  end

  // Explicit wrap so non-power-of-two NPORT works.
  always_comb begin
    if (win == PortW'(NPORT - 1)) begin
      rr_next = '0;
    end else begin
      rr_next = win + 1'b1;
    end
  end

  assign push   = found;
  assign pop    = db_out_valid && (count != '0);
  assign orphan = db_out_valid && (count == '0);
  assign head   = tag_mem[rd_ptr];

  always_comb begin
    head_onehot       = '0;
    head_onehot[head] = 1'b1;
  end

  // Round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= rr_next;
    end
  end

  // Tag FIFO storage and pointers; pointers wrap naturally at TAG_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(TAG_DEPTH); i++) begin
        tag_mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        tag_mem[wr_ptr] <= win;
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue path towards db_top; key/flag hold between issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_in_valid <= 1'b0;
      db_in_key   <= '0;
      db_in_flag  <= '0;
    end else begin
      db_in_valid <= push;
      if (push) begin
        db_in_key  <= req_key[win*KEY_SIZE +: KEY_SIZE];
        db_in_flag <= req_flag[win*4 +: 4];
      end
    end
  end

  // Return path: steer the result to the FIFO head; orphans are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= '0;
      resp_flag  <= '0;
      err_orphan <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (pop) begin
        resp_valid <= head_onehot;
        resp_flag  <= db_out_flag;
      end
      if (orphan) begin
        err_orphan <= 1'b1;
      end
    end
  end

`ifdef DB_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt  <= '0;
      orphan_cnt <= '0;
    end else begin
      for (int p = 0; p < int'(NPORT); p++) begin
        if (push && (win == PortW'(p))) begin
          grant_cnt[p*32 +: 32] <= grant_cnt[p*32 +: 32] + 32'd1;
        end
      end
      if (orphan) begin
        orphan_cnt <= orphan_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
